// File: rtl/psum_requant_pkg.sv
// Shared sizes and fixed-point formats for the psum-to-activation back-end.
package psum_requant_pkg;

  localparam int unsigned PSUM_DATA_SIZE = 12;
  localparam int unsigned ACT_DATA_SIZE  = 8;
  localparam int unsigned PSUM_FRAC      = 5;
  localparam int unsigned ACT_FRAC       = 3;

  localparam logic [ACT_DATA_SIZE-1:0] ACT_MAX = 8'h7F;
  localparam logic [ACT_DATA_SIZE-1:0] ACT_MIN = 8'h80;

  // Rounded/shifted psum carries one guard bit so the rounding add cannot overflow.
  localparam int unsigned Q_W = PSUM_DATA_SIZE + 1;

endpackage

// File: rtl/requant_sat.sv
// Combinational ReLU + saturation of a shifted psum down to an 8-bit activation.
module requant_sat
  import psum_requant_pkg::*;
(
  input  logic [Q_W-1:0]           q_i,
  input  logic                     relu_en_i,
  output logic [ACT_DATA_SIZE-1:0] act_o,
  output logic                     sat_o
);

  localparam logic signed [Q_W-1:0] QMax = Q_W'(ACT_MAX);
  localparam logic signed [Q_W-1:0] QMin = {{(Q_W - ACT_DATA_SIZE){1'b1}}, ACT_MIN};

  logic signed [Q_W-1:0] qs;

  always_comb begin
    qs    = $signed(q_i);
    act_o = q_i[ACT_DATA_SIZE-1:0];
    sat_o = 1'b0;
    // ReLU wins over negative saturation: a clamped negative is not a saturation event.
    if (relu_en_i && qs[Q_W-1]) begin
      act_o = '0;
    end else if (qs > QMax) begin
      act_o = ACT_MAX;
      sat_o = 1'b1;
    end else if (qs < QMin) begin
      act_o = ACT_MIN;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Two-stage valid/ready pipeline: round+shift, then ReLU/saturate, with a sticky
// saturation-event counter.
module psum_requant
  import psum_requant_pkg::*;
#(
  parameter int unsigned SHIFT = PSUM_FRAC - ACT_FRAC,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      relu_en,
  input  logic                      sat_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PSUM_DATA_SIZE-1:0] in_psum,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACT_DATA_SIZE-1:0]  out_act,
  output logic                      out_last,
  output logic [CNT_W-1:0]          sat_cnt
);

  if (SHIFT < 1 || SHIFT > 6) begin : g_bad_shift
    $error("psum_requant: SHIFT must be in 1..6");
  end

  localparam logic signed [Q_W-1:0] RoundHalf = Q_W'(1) << (SHIFT - 1);

  logic                     s1_valid_q, s1_valid_d;
  logic [Q_W-1:0]           s1_q_q, s1_q_d;
  logic                     s1_relu_q, s1_relu_d;
  logic                     s1_last_q, s1_last_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [ACT_DATA_SIZE-1:0] s2_act_q, s2_act_d;
  logic                     s2_last_q, s2_last_d;
  logic [CNT_W-1:0]         sat_cnt_q, sat_cnt_d;

  logic                     s2_load;
  logic                     in_fire;
  logic                     s1_adv;
  logic signed [Q_W-1:0]    rounded;
  logic signed [Q_W-1:0]    shifted;
  logic [ACT_DATA_SIZE-1:0] sat_act;
  logic                     sat_evt;

  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign s1_adv   = s1_valid_q & s2_load;

  assign rounded = $signed({in_psum[PSUM_DATA_SIZE-1], in_psum}) + RoundHalf;
  assign shifted = rounded >>> SHIFT;

  requant_sat u_requant_sat (
    .q_i       (s1_q_q),
    .relu_en_i (s1_relu_q),
    .act_o     (sat_act),
    .sat_o     (sat_evt)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_q_d     = s1_q_q;
    s1_relu_d  = s1_relu_q;
    s1_last_d  = s1_last_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_q_d     = shifted;
      s1_relu_d  = relu_en;
      s1_last_d  = in_last;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_act_d   = s2_act_q;
    s2_last_d  = s2_last_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_act_d   = sat_act;
      s2_last_d  = s1_last_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s1_adv && sat_evt && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q_q     <= '0;
      s1_relu_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_act_q   <= '0;
      s2_last_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q_q     <= s1_q_d;
      s1_relu_q  <= s1_relu_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_act_q   <= s2_act_d;
      s2_last_q  <= s2_last_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_act   = s2_act_q;
  assign out_last  = s2_last_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
